// File: rtl/odd_seq_pkg.sv
// Shared state encoding and constants for the odd-sequence checker.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] RESET_EXP = 8'h01;

endpackage

// File: rtl/odd_seq_err_cnt.sv
// Saturating error counter, 1-cycle update; no backpressure.
// A clear arriving with an error restarts the count at 1 so that error is not lost.
module odd_seq_err_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (inc_i && clr_i) begin
            cnt_q <= 8'd1;
        end else if (clr_i) begin
            cnt_q <= 8'd0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Checks an odd-counter stream advancing by STEP (mod 256); all outputs registered, 1-cycle latency.
// in_ready drops for one cycle after a lost lock; optional err_cnt under ODD_SEQ_ERR_CNT_EN.
module odd_seq_checker
    import odd_seq_pkg::*;
#(
    parameter int STEP     = 2,
    parameter int LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       clr_err,
    output logic       locked,
    output logic [7:0] exp_data,
    output logic       err_pulse,
`ifdef ODD_SEQ_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       err_sticky
);

    localparam logic [7:0] STEP_B  = 8'(STEP);
    localparam logic [3:0] LOCK_M1 = 4'(LOCK_CNT - 1);

    state_t     state_q;
    logic [3:0] match_cnt_q;
    logic [7:0] exp_q;
    logic       rdy_q;
    logic       locked_q;
    logic       err_pulse_q;
    logic       sticky_q;

    logic xfer;
    logic match;
    logic even;
    logic err_d;

    assign xfer  = in_valid && rdy_q;
    assign match = (in_data == exp_q);
    assign even  = ~in_data[0];

    // An odd mismatch while still syncing only reseeds; it is not an error.
    always_comb begin
        err_d = 1'b0;
        if (xfer) begin
            case (state_q)
                ST_IDLE:   err_d = even;
                ST_SYNC:   err_d = even && !match;
                ST_LOCKED: err_d = !match;
                default:   err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            match_cnt_q <= 4'd0;
            exp_q       <= RESET_EXP;
            rdy_q       <= 1'b1;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            err_pulse_q <= err_d;
            if (err_d) begin
                sticky_q <= 1'b1;
            end else if (clr_err) begin
                sticky_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (xfer && !even) begin
                        state_q     <= ST_SYNC;
                        exp_q       <= in_data + STEP_B;
                        match_cnt_q <= 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        if (match) begin
                            exp_q       <= exp_q + STEP_B;
                            match_cnt_q <= match_cnt_q + 4'd1;
                            if (match_cnt_q == LOCK_M1) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (!even) begin
                            exp_q       <= in_data + STEP_B;
                            match_cnt_q <= 4'd0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer) begin
                        if (match) begin
                            exp_q <= exp_q + STEP_B;
                        end else begin
                            state_q  <= ST_RECOVER;
                            locked_q <= 1'b0;
                            rdy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

`ifdef ODD_SEQ_ERR_CNT_EN
    odd_seq_err_cnt u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (err_d),
        .clr_i (clr_err),
        .cnt_o (err_cnt)
    );
`endif

    assign in_ready   = rdy_q;
    assign locked     = locked_q;
    assign exp_data   = exp_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed vector bench for odd_seq_checker (STEP=2, LOCK_CNT=2).
module tb_odd_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clr_err;
    logic       locked;
    logic [7:0] exp_data;
    logic       err_pulse;
    logic       err_sticky;
`ifdef ODD_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    odd_seq_checker #(.STEP(2), .LOCK_CNT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clr_err    (clr_err),
        .locked     (locked),
        .exp_data   (exp_data),
        .err_pulse  (err_pulse),
`ifdef ODD_SEQ_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .err_sticky (err_sticky)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        logic       rst;
        logic       rdy;
        logic       lck;
        logic [7:0] exd;
        logic       ep;
        logic       es;
        logic [7:0] ec;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    function automatic vec_t mk(logic v, logic [7:0] d, logic clr, logic rst, logic rdy,
                                logic lck, logic [7:0] exd, logic ep, logic es, logic [7:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.rst = rst; r.rdy = rdy;
        r.lck = lck; r.exd = exd; r.ep = ep; r.es = es; r.ec = ec;
        return r;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_out(string tag, logic rdy, logic lck, logic [7:0] exd,
                             logic ep, logic es, logic [7:0] ec);
        n_vec++;
        chk({tag, " in_ready"},   {7'd0, in_ready},   {7'd0, rdy});
        chk({tag, " locked"},     {7'd0, locked},     {7'd0, lck});
        chk({tag, " exp_data"},   exp_data,           exd);
        chk({tag, " err_pulse"},  {7'd0, err_pulse},  {7'd0, ep});
        chk({tag, " err_sticky"}, {7'd0, err_sticky}, {7'd0, es});
`ifdef ODD_SEQ_ERR_CNT_EN
        chk({tag, " err_cnt"},    err_cnt,            ec);
`else
        if (ec > 8'd255) n_miss++;
`endif
    endtask

    task automatic step(logic v, logic [7:0] d, logic c);
        in_valid = v;
        in_data  = d;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          v  d    clr rst rdy lck exp  ep es ec
        tbl[0]  = mk(1, 1,   0,  0,  1,  0,  3,   0, 0, 0);
        tbl[1]  = mk(1, 3,   0,  0,  1,  0,  5,   0, 0, 0);
        tbl[2]  = mk(1, 5,   0,  0,  1,  1,  7,   0, 0, 0);
        tbl[3]  = mk(1, 7,   0,  0,  1,  1,  9,   0, 0, 0);
        tbl[4]  = mk(0, 99,  0,  0,  1,  1,  9,   0, 0, 0);
        tbl[5]  = mk(1, 11,  0,  0,  0,  0,  9,   1, 1, 1);
        tbl[6]  = mk(1, 13,  0,  0,  1,  0,  9,   0, 1, 1);
        tbl[7]  = mk(1, 4,   0,  0,  1,  0,  9,   1, 1, 2);
        tbl[8]  = mk(1, 5,   0,  0,  1,  0,  7,   0, 1, 2);
        tbl[9]  = mk(1, 7,   0,  0,  1,  0,  9,   0, 1, 2);
        tbl[10] = mk(1, 9,   0,  0,  1,  1,  11,  0, 1, 2);
        tbl[11] = mk(0, 0,   1,  0,  1,  1,  11,  0, 0, 0);
        tbl[12] = mk(0, 0,   0,  1,  1,  0,  1,   0, 0, 0);
        tbl[13] = mk(1, 247, 0,  0,  1,  0,  249, 0, 0, 0);
        tbl[14] = mk(1, 101, 0,  0,  1,  0,  103, 0, 0, 0);
        tbl[15] = mk(1, 245, 0,  0,  1,  0,  247, 0, 0, 0);
        tbl[16] = mk(1, 247, 0,  0,  1,  0,  249, 0, 0, 0);
        tbl[17] = mk(1, 249, 0,  0,  1,  1,  251, 0, 0, 0);
        tbl[18] = mk(1, 251, 0,  0,  1,  1,  253, 0, 0, 0);
        tbl[19] = mk(1, 253, 0,  0,  1,  1,  255, 0, 0, 0);
        tbl[20] = mk(1, 255, 0,  0,  1,  1,  1,   0, 0, 0);
        tbl[21] = mk(1, 1,   0,  0,  1,  1,  3,   0, 0, 0);
        tbl[22] = mk(1, 3,   0,  0,  1,  1,  5,   0, 0, 0);
        tbl[23] = mk(1, 8,   1,  0,  0,  0,  5,   1, 1, 1);
        tbl[24] = mk(0, 0,   0,  0,  1,  0,  5,   0, 1, 1);
        tbl[25] = mk(1, 15,  0,  0,  1,  0,  17,  0, 1, 1);
        tbl[26] = mk(1, 6,   0,  0,  1,  0,  17,  1, 1, 2);
        tbl[27] = mk(0, 0,   1,  0,  1,  0,  17,  0, 0, 0);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        clr_err  = 1'b0;
        @(posedge clk);
        #1;
        check_out("reset", 1, 0, 8'd1, 0, 0, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst;
            step(tbl[i].v, tbl[i].d, tbl[i].clr);
            check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].lck, tbl[i].exd,
                      tbl[i].ep, tbl[i].es, tbl[i].ec);
        end

        // Lock again, then drop reset in between clock edges.
        step(1, 21, 0);
        step(1, 23, 0);
        step(1, 25, 0);
        check_out("relock", 1, 1, 8'd27, 0, 0, 8'd0);
        #2 reset = 1'b1;
        #1;
        check_out("async_rst", 1, 0, 8'd1, 0, 0, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 21, 0);
        check_out("reseed21", 1, 0, 8'd23, 0, 0, 8'd0);

`ifdef ODD_SEQ_ERR_CNT_EN
        for (int k = 0; k < 260; k++) step(1, 8'd22, 0);
        check_out("cnt_sat", 1, 0, 8'd23, 1, 1, 8'd255);
        step(0, 0, 1);
        check_out("cnt_clr", 1, 0, 8'd23, 0, 0, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
